// File: rtl/expr_recognizer.sv
// Streaming ASCII arithmetic-expression recognizer: multi-digit literals,
// configurable operators and bounded parenthesis nesting, with a sticky error code.
module expr_recognizer #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_DEPTH  = 3,
  parameter logic [3:0]  OP_MASK    = 4'b0101
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       out,
  output logic       fail,
  output logic [1:0] err_code,
  output logic [3:0] depth
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] DIG_MAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] DEP_MAX = CW'(MAX_DEPTH);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SYNTAX = 2'b01;
  localparam logic [1:0] ERR_LONG   = 2'b10;
  localparam logic [1:0] ERR_DEPTH  = 2'b11;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_OPEN  = 8'h28;
  localparam logic [7:0] CH_CLOSE = 8'h29;

  typedef enum logic [1:0] {
    EXPECT_OPERAND,
    IN_NUMBER,
    AFTER_CLOSE,
    FAILED
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   dcnt, dcnt_n;
  logic [CW-1:0]   depth_n;
  logic [1:0]      err_n;
  logic            fail_n;
  logic            out_n;

  logic            is_digit_c;
  logic            is_op_c;
  logic            is_open_c;
  logic            is_close_c;

  // Character classification; a disabled operator falls into "other".
  always_comb begin
    is_digit_c = (in >= CH_ZERO) && (in <= CH_NINE);
    is_op_c    = ((in == CH_PLUS)  && OP_MASK[0]) ||
                 ((in == CH_MINUS) && OP_MASK[1]) ||
                 ((in == CH_STAR)  && OP_MASK[2]) ||
                 ((in == CH_SLASH) && OP_MASK[3]);
    is_open_c  = (in == CH_OPEN);
    is_close_c = (in == CH_CLOSE);
  end

  // State register; every output only moves on a qualified character.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= EXPECT_OPERAND;
      dcnt     <= '0;
      depth    <= '0;
      err_code <= ERR_NONE;
      fail     <= 1'b0;
      out      <= 1'b0;
    end else if (in_valid) begin
      state    <= state_n;
      dcnt     <= dcnt_n;
      depth    <= depth_n;
      err_code <= err_n;
      fail     <= fail_n;
      out      <= out_n;
    end
  end

  // Next-state logic; FAILED is absorbing so err_code is written only once.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    depth_n = depth;
    err_n   = err_code;
    fail_n  = fail;

    case (state)
      EXPECT_OPERAND: begin
        if (is_digit_c) begin
          state_n = IN_NUMBER;
          dcnt_n  = CW'(1);
        end else if (is_open_c) begin
          if (depth < DEP_MAX) begin
            depth_n = depth + CW'(1);
          end else begin
            state_n = FAILED;
            fail_n  = 1'b1;
            err_n   = ERR_DEPTH;
          end
        end else begin
          state_n = FAILED;
          fail_n  = 1'b1;
          err_n   = ERR_SYNTAX;
        end
      end

      IN_NUMBER: begin
        if (is_digit_c) begin
          if (dcnt < DIG_MAX) begin
            dcnt_n = dcnt + CW'(1);
          end else begin
            state_n = FAILED;
            fail_n  = 1'b1;
            err_n   = ERR_LONG;
          end
        end else if (is_op_c) begin
          state_n = EXPECT_OPERAND;
          dcnt_n  = '0;
        end else if (is_close_c && (depth != '0)) begin
          state_n = AFTER_CLOSE;
          depth_n = depth - CW'(1);
          dcnt_n  = '0;
        end else begin
          state_n = FAILED;
          fail_n  = 1'b1;
          err_n   = ERR_SYNTAX;
        end
      end

      AFTER_CLOSE: begin
        if (is_op_c) begin
          state_n = EXPECT_OPERAND;
        end else if (is_close_c && (depth != '0)) begin
          depth_n = depth - CW'(1);
        end else begin
          state_n = FAILED;
          fail_n  = 1'b1;
          err_n   = ERR_SYNTAX;
        end
      end

      default: ;
    endcase

    out_n = ((state_n == IN_NUMBER) || (state_n == AFTER_CLOSE)) && (depth_n == '0);
  end

endmodule

// File: tb/tb_expr_recognizer.sv
// Self-checking bench for expr_recognizer: directed vector table, async-reset
// sequences, and random streams scored against a follow-set grammar model.
module tb_expr_recognizer;

  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned MAX_DEPTH  = 3;
  localparam logic [3:0]  OP_MASK    = 4'b0101;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;
  logic       out;
  logic       fail;
  logic [1:0] err_code;
  logic [3:0] depth;

  int n_total = 0;
  int n_pass  = 0;

  expr_recognizer #(
    .MAX_DIGITS(MAX_DIGITS),
    .MAX_DEPTH (MAX_DEPTH),
    .OP_MASK   (OP_MASK)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .in      (in),
    .in_valid(in_valid),
    .out     (out),
    .fail    (fail),
    .err_code(err_code),
    .depth   (depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic apply(input logic [7:0] c, input logic v);
    @(negedge clk);
    in = c;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  // Grammar model: which character class may follow which, plus counted limits.
  localparam int C_DIG = 0, C_OP = 1, C_OPN = 2, C_CLS = 3, C_OTH = 4;
  bit follows [5][5];
  int m_prev, m_run, m_depth, m_err;
  bit m_fail;

  function automatic int classify(input logic [7:0] c);
    if (c >= "0" && c <= "9") return C_DIG;
    if ((c == "+" && OP_MASK[0]) || (c == "-" && OP_MASK[1]) ||
        (c == "*" && OP_MASK[2]) || (c == "/" && OP_MASK[3])) return C_OP;
    if (c == "(") return C_OPN;
    if (c == ")") return C_CLS;
    return C_OTH;
  endfunction

  task automatic m_reset();
    m_prev = C_OP;  // stream start admits the same followers as after an operator
    m_run = 0; m_depth = 0; m_err = 0; m_fail = 0;
  endtask

  task automatic m_step(input logic [7:0] c);
    int k;
    if (m_fail) return;
    k = classify(c);
    if (!follows[m_prev][k]) begin m_fail = 1; m_err = 1; end
    else if (k == C_DIG && m_prev == C_DIG && m_run == int'(MAX_DIGITS)) begin m_fail = 1; m_err = 2; end
    else if (k == C_OPN && m_depth == int'(MAX_DEPTH)) begin m_fail = 1; m_err = 3; end
    else if (k == C_CLS && m_depth == 0) begin m_fail = 1; m_err = 1; end
    else begin
      m_run = (k == C_DIG) ? ((m_prev == C_DIG) ? m_run + 1 : 1) : 0;
      if (k == C_OPN) m_depth++;
      if (k == C_CLS) m_depth--;
      m_prev = (k == C_OPN) ? C_OP : k;
    end
  endtask

  function automatic logic m_out();
    return !m_fail && (m_prev == C_DIG || m_prev == C_CLS) && m_depth == 0;
  endfunction

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] ch;
    logic       e_out;
    logic       e_fail;
    logic [1:0] e_err;
    logic [3:0] e_dep;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] c,
                     input logic o, input logic f, input logic [1:0] e, input logic [3:0] d);
    vec_t t;
    t.rst = r; t.vld = v; t.ch = c; t.e_out = o; t.e_fail = f; t.e_err = e; t.e_dep = d;
    vecs.push_back(t);
  endtask

  string alpha;

  initial begin
    follows[C_OP][C_DIG] = 1;  follows[C_OP][C_OPN] = 1;
    follows[C_DIG][C_DIG] = 1; follows[C_DIG][C_OP] = 1; follows[C_DIG][C_CLS] = 1;
    follows[C_CLS][C_OP] = 1;  follows[C_CLS][C_CLS] = 1;

    // "12+3*45"
    add(1,1,"1",1,0,0,0); add(0,1,"2",1,0,0,0); add(0,1,"+",0,0,0,0); add(0,1,"3",1,0,0,0);
    add(0,1,"*",0,0,0,0); add(0,1,"4",1,0,0,0); add(0,1,"5",1,0,0,0);
    // "(1+(2*3))"
    add(1,1,"(",0,0,0,1); add(0,1,"1",0,0,0,1); add(0,1,"+",0,0,0,1); add(0,1,"(",0,0,0,2);
    add(0,1,"2",0,0,0,2); add(0,1,"*",0,0,0,2); add(0,1,"3",0,0,0,2); add(0,1,")",0,0,0,1);
    add(0,1,")",1,0,0,0);
    // "((((" then "1)"
    add(1,1,"(",0,0,0,1); add(0,1,"(",0,0,0,2); add(0,1,"(",0,0,0,3); add(0,1,"(",0,1,3,3);
    add(0,1,"1",0,1,3,3); add(0,1,")",0,1,3,3);
    // "12345"
    add(1,1,"1",1,0,0,0); add(0,1,"2",1,0,0,0); add(0,1,"3",1,0,0,0); add(0,1,"4",1,0,0,0);
    add(0,1,"5",0,1,2,0);
    // "1-2" with '-' disabled
    add(1,1,"1",1,0,0,0); add(0,1,"-",0,1,1,0); add(0,1,"2",0,1,1,0);
    // "1+" with in_valid gaps carrying characters that must be ignored
    add(1,1,"1",1,0,0,0); add(0,0,"x",1,0,0,0); add(0,0,"x",1,0,0,0); add(0,0,")",1,0,0,0);
    add(0,1,"+",0,0,0,0); add(0,0,"(",0,0,0,0); add(0,0,"(",0,0,0,0); add(0,0,"7",0,0,0,0);
    // "007"
    add(1,1,"0",1,0,0,0); add(0,1,"0",1,0,0,0); add(0,1,"7",1,0,0,0);
    // "12)" close at depth 0
    add(1,1,"1",1,0,0,0); add(0,1,"2",1,0,0,0); add(0,1,")",0,1,1,0);
    // "(5))" extra close after a close
    add(1,1,"(",0,0,0,1); add(0,1,"5",0,0,0,1); add(0,1,")",1,0,0,0); add(0,1,")",0,1,1,0);
    // "(1)2" digit after close, then more input after failure
    add(1,1,"(",0,0,0,1); add(0,1,"1",0,0,0,1); add(0,1,")",1,0,0,0); add(0,1,"2",0,1,1,0);
    add(0,1,"(",0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b1;
        #1;
        chk($sformatf("reset_out[%0d]", i), 8'(out), 8'(0));
        chk($sformatf("reset_fail[%0d]", i), 8'(fail), 8'(0));
        chk($sformatf("reset_err[%0d]", i), 8'(err_code), 8'(0));
        chk($sformatf("reset_depth[%0d]", i), 8'(depth), 8'(0));
        #1;
        clr = 1'b0;
      end
      apply(vecs[i].ch, vecs[i].vld);
      chk($sformatf("vec_out[%0d]", i), 8'(out), 8'(vecs[i].e_out));
      chk($sformatf("vec_fail[%0d]", i), 8'(fail), 8'(vecs[i].e_fail));
      chk($sformatf("vec_err[%0d]", i), 8'(err_code), 8'(vecs[i].e_err));
      chk($sformatf("vec_depth[%0d]", i), 8'(depth), 8'(vecs[i].e_dep));
    end

    // Async clear mid-cycle after "(7", then "9" parses as a fresh stream
    do_reset();
    apply("(", 1); apply("7", 1);
    chk("async_pre_depth", 8'(depth), 8'(1));
    #2 clr = 1'b1;
    #1;
    chk("async_depth", 8'(depth), 8'(0));
    chk("async_out", 8'(out), 8'(0));
    clr = 1'b0;
    apply("9", 1);
    chk("async_then_out", 8'(out), 8'(1));
    chk("async_then_depth", 8'(depth), 8'(0));

    // Async clear releases a failed stream
    apply(")", 1);
    chk("fail_pre", 8'({fail, err_code}), 8'(3'b101));
    #2 clr = 1'b1;
    #1;
    chk("fail_clr_fail", 8'(fail), 8'(0));
    chk("fail_clr_err", 8'(err_code), 8'(0));
    chk("fail_clr_out", 8'(out), 8'(0));

    // clr held across a clock edge overrides a valid character
    @(negedge clk);
    in = "5"; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_hold_out", 8'(out), 8'(0));
    clr = 1'b0;
    apply("5", 1);
    chk("clr_release_out", 8'(out), 8'(1));

    // Random streams against the grammar model
    alpha = "0123456789+-*/()x";
    for (int s = 0; s < 250; s++) begin
      int len;
      do_reset();
      m_reset();
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        logic [7:0] c;
        logic v;
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      c = alpha[$urandom_range(0, 9)];
        else if (r < 70) c = alpha[$urandom_range(10, 13)];
        else if (r < 82) c = "(";
        else if (r < 94) c = ")";
        else             c = "x";
        v = ($urandom_range(0, 9) != 0);
        apply(c, v);
        if (v) m_step(c);
        chk($sformatf("rnd_out[%0d.%0d]", s, k), 8'(out), 8'(m_out()));
        chk($sformatf("rnd_fail[%0d.%0d]", s, k), 8'(fail), 8'(m_fail));
        chk($sformatf("rnd_err[%0d.%0d]", s, k), 8'(err_code), 8'(m_err));
        chk($sformatf("rnd_depth[%0d.%0d]", s, k), 8'(depth), 8'(m_depth));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
